// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request scheduler.
package elevator_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        MOVE = 2'd2,
        DOOR = 2'd3
    } state_t;

    localparam int NUM_FLOORS_DEFAULT = 12;
    localparam int FLOOR_W            = 4;

    // Floor index. Four bits cap the building at 16 floors.
    typedef logic [FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/request_scheduler_scan.sv
// SCAN target selection: nearest call ahead in the current direction,
// otherwise nearest call behind with the direction reversed.
module scan_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [3:0]            current_floor,
    input  logic                  dir_up,
    output logic                  found,
    output logic [3:0]            floor,
    output logic                  dir_next
);

    logic   up_found_s;
    logic   dn_found_s;
    floor_t up_floor_s;
    floor_t dn_floor_s;

    // Nearest pending floor above and below the car; only floors that
    // exist in the pending vector are ever considered.
    always_comb begin
        up_found_s = 1'b0;
        up_floor_s = 4'd0;
        dn_found_s = 1'b0;
        dn_floor_s = 4'd0;
        // Scan downwards so the last hit is the closest floor above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                up_found_s = 1'b1;
                up_floor_s = floor_t'(i);
            end else begin
                up_found_s = up_found_s;
                up_floor_s = up_floor_s;
            end
        end
        // Scan upwards so the last hit is the closest floor below.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                dn_found_s = 1'b1;
                dn_floor_s = floor_t'(i);
            end else begin
                dn_found_s = dn_found_s;
                dn_floor_s = dn_floor_s;
            end
        end
    end

    // Prefer the current direction; fall back to the opposite one.
    always_comb begin
        found    = 1'b0;
        floor    = 4'd0;
        dir_next = dir_up;
        if (dir_up) begin
            if (up_found_s) begin
                found    = 1'b1;
                floor    = up_floor_s;
                dir_next = 1'b1;
            end else if (dn_found_s) begin
                found    = 1'b1;
                floor    = dn_floor_s;
                dir_next = 1'b0;
            end else begin
                found    = 1'b0;
                floor    = 4'd0;
                dir_next = dir_up;
            end
        end else begin
            if (dn_found_s) begin
                found    = 1'b1;
                floor    = dn_floor_s;
                dir_next = 1'b0;
            end else if (up_found_s) begin
                found    = 1'b1;
                floor    = up_floor_s;
                dir_next = 1'b1;
            end else begin
                found    = 1'b0;
                floor    = 4'd0;
                dir_next = dir_up;
            end
        end
    end

endmodule

// File: rtl/request_scheduler.sv
// Elevator request scheduler: collects floor calls, picks the next stop
// with SCAN, handshakes the target to the motion controller and holds the
// door open for a fixed number of cycles at each stop.
module request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEFAULT,
    parameter int DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] press,
    input  logic                  press_valid,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    input  logic                  target_ready,
    input  logic                  arrived,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [3:0]            current_floor,
    output logic [NUM_FLOORS-1:0] pending
);

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    floor_t                current_floor_q, current_floor_d;
    floor_t                target_floor_q, target_floor_d;
    logic                  dir_up_q, dir_up_d;
    logic                  target_valid_q, target_valid_d;
    logic                  door_open_q, door_open_d;
    logic [7:0]            door_cnt_q, door_cnt_d;

    logic                  scan_found_s;
    logic [3:0]            scan_floor_s;
    logic                  scan_dir_s;
    logic [NUM_FLOORS-1:0] cur_mask_s;
    logic [NUM_FLOORS-1:0] tgt_mask_s;
    logic [NUM_FLOORS-1:0] drop_mask_s;
    logic [NUM_FLOORS-1:0] press_s;
    logic                  here_call_s;
    logic                  door_last_s;

    scan_select #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_scan (
        .pending       (pending_q),
        .current_floor (current_floor_q),
        .dir_up        (dir_up_q),
        .found         (scan_found_s),
        .floor         (scan_floor_s),
        .dir_next      (scan_dir_s)
    );

    assign cur_mask_s  = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << current_floor_q;
    assign tgt_mask_s  = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << target_floor_q;
    assign press_s     = press_valid ? press : {NUM_FLOORS{1'b0}};
    assign here_call_s = |(pending_q & cur_mask_s);
    assign door_last_s = (door_cnt_q == 8'(DOOR_CYCLES - 1));

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A call at the floor we are parked on opens the door at once.
                if (here_call_s) begin
                    state_d = DOOR;
                end else if (scan_found_s) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (target_ready) begin
                    state_d = MOVE;
                end else begin
                    state_d = REQ;
                end
            end
            MOVE: begin
                if (arrived) begin
                    state_d = DOOR;
                end else begin
                    state_d = MOVE;
                end
            end
            DOOR: begin
                if (door_last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DOOR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values; outputs follow the next state so
    // they are registered alongside it.
    always_comb begin
        current_floor_d = current_floor_q;
        target_floor_d  = target_floor_q;
        dir_up_d        = dir_up_q;
        door_cnt_d      = door_cnt_q;
        drop_mask_s     = {NUM_FLOORS{1'b0}};
        case (state_q)
            IDLE: begin
                if (here_call_s) begin
                    drop_mask_s = cur_mask_s;
                    door_cnt_d  = 8'd0;
                end else if (scan_found_s) begin
                    target_floor_d = scan_floor_s;
                    dir_up_d       = scan_dir_s;
                end else begin
                    target_floor_d = target_floor_q;
                end
            end
            REQ: begin
                target_floor_d = target_floor_q;
            end
            MOVE: begin
                // Clearing after the OR means a same-cycle press at the
                // target is lost: the clear wins.
                if (arrived) begin
                    current_floor_d = target_floor_q;
                    drop_mask_s     = tgt_mask_s;
                    door_cnt_d      = 8'd0;
                end else begin
                    current_floor_d = current_floor_q;
                end
            end
            DOOR: begin
                // Calls at the open door are already being served.
                drop_mask_s = cur_mask_s;
                if (door_last_s) begin
                    door_cnt_d = 8'd0;
                end else begin
                    door_cnt_d = door_cnt_q + 8'd1;
                end
            end
            default: begin
                door_cnt_d = 8'd0;
            end
        endcase
        pending_d      = (pending_q | press_s) & ~drop_mask_s;
        target_valid_d = (state_d == REQ);
        door_open_d    = (state_d == DOOR);
    end

    // Datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q       <= {NUM_FLOORS{1'b0}};
            current_floor_q <= 4'd0;
            target_floor_q  <= 4'd0;
            dir_up_q        <= 1'b1;
            target_valid_q  <= 1'b0;
            door_open_q     <= 1'b0;
            door_cnt_q      <= 8'd0;
        end else begin
            pending_q       <= pending_d;
            current_floor_q <= current_floor_d;
            target_floor_q  <= target_floor_d;
            dir_up_q        <= dir_up_d;
            target_valid_q  <= target_valid_d;
            door_open_q     <= door_open_d;
            door_cnt_q      <= door_cnt_d;
        end
    end

    assign pending       = pending_q;
    assign current_floor = current_floor_q;
    assign target_floor  = target_floor_q;
    assign dir_up        = dir_up_q;
    assign target_valid  = target_valid_q;
    assign door_open     = door_open_q;

endmodule

// File: tb/tb_request_scheduler.sv
// Self-checking bench for request_scheduler: directed scenarios followed by
// random traffic, all compared every cycle against a behavioural model.
module tb_request_scheduler;

    localparam int NF = 12;
    localparam int DC = 8;
    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_MOVE = 2;
    localparam int S_DOOR = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] press;
    logic        press_valid;
    logic        target_ready;
    logic        arrived;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic        door_open;
    logic        dir_up;
    logic [3:0]  current_floor;
    logic [11:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int        m_st;
    int        m_cur;
    int        m_tgt;
    int        m_left;
    bit        m_dir;
    bit [11:0] m_pend;

    always #5 clk = ~clk;

    request_scheduler #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
        .clk           (clk),
        .rst           (rst),
        .press         (press),
        .press_valid   (press_valid),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .target_ready  (target_ready),
        .arrived       (arrived),
        .door_open     (door_open),
        .dir_up        (dir_up),
        .current_floor (current_floor),
        .pending       (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Nearest call by distance, preferred direction first.
    function automatic void scan_model(input bit [11:0] p, input int cur, input bit dir,
                                       output bit f, output int fl, output bit nd);
        int c;
        f = 1'b0; fl = 0; nd = dir;
        for (int d = 1; d < NF; d++) begin
            c = dir ? cur + d : cur - d;
            if (!f && c >= 0 && c < NF && p[c]) begin f = 1'b1; fl = c; end
        end
        if (!f) begin
            for (int d = 1; d < NF; d++) begin
                c = dir ? cur - d : cur + d;
                if (!f && c >= 0 && c < NF && p[c]) begin f = 1'b1; fl = c; nd = !dir; end
            end
        end
    endfunction

    task automatic model_step();
        bit [11:0] np;
        bit f; int fl; bit nd;
        if (!rst) begin
            m_st = S_IDLE; m_cur = 0; m_tgt = 0; m_left = 0; m_dir = 1'b1; m_pend = '0;
        end else begin
            np = m_pend | (press_valid ? press : 12'd0);
            case (m_st)
                S_IDLE: begin
                    if (m_pend[m_cur]) begin
                        np[m_cur] = 1'b0; m_st = S_DOOR; m_left = DC;
                    end else begin
                        scan_model(m_pend, m_cur, m_dir, f, fl, nd);
                        if (f) begin m_tgt = fl; m_dir = nd; m_st = S_REQ; end
                    end
                end
                S_REQ:  if (target_ready) m_st = S_MOVE;
                S_MOVE: if (arrived) begin
                    m_cur = m_tgt; np[m_tgt] = 1'b0; m_st = S_DOOR; m_left = DC;
                end
                S_DOOR: begin
                    np[m_cur] = 1'b0;
                    m_left--;
                    if (m_left == 0) m_st = S_IDLE;
                end
                default: m_st = S_IDLE;
            endcase
            m_pend = np;
        end
    endtask

    task automatic compare_all();
        check("pending",       32'(pending),       32'(m_pend));
        check("current_floor", 32'(current_floor), 32'(m_cur));
        check("target_floor",  32'(target_floor),  32'(m_tgt));
        check("dir_up",        32'(dir_up),        32'(m_dir));
        check("target_valid",  32'(target_valid),  32'(m_st == S_REQ));
        check("door_open",     32'(door_open),     32'(m_st == S_DOOR));
    endtask

    task automatic tick(input logic [11:0] p, input logic pv, input logic rdy,
                        input logic arr, input logic r);
        @(negedge clk);
        press = p; press_valid = pv; target_ready = rdy; arrived = arr; rst = r;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wait_door_end();
        for (int i = 0; i < 40; i++) begin
            if (!door_open) break;
            tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("door_end", 32'(door_open), 32'd0);
    endtask

    // Call floor f and drive the car there; returns with the door open.
    task automatic go_floor(input int f);
        tick(12'd1 << f, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (door_open) break;
            tick(12'd0, 1'b0, 1'b1, logic'(m_st == S_MOVE), 1'b1);
        end
        check("go_floor_reach", 32'(door_open), 32'd1);
    endtask

    task automatic serve_next(output int f, output bit d);
        for (int i = 0; i < 30; i++) begin
            if (target_valid) break;
            tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("serve_valid", 32'(target_valid), 32'd1);
        f = int'(target_floor);
        d = dir_up;
        tick(12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(12'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_door_end();
    endtask

    initial begin
        int  n;
        int  fl[3];
        bit  dr[3];

        rst = 1'b0; press = 12'd0; press_valid = 1'b0; target_ready = 1'b0; arrived = 1'b0;

        // Reset state
        tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_dir", 32'(dir_up), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);

        // Single call from floor 0 to floor 4 with a stalled handshake
        tick(12'h010, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("call_tv", 32'(target_valid), 32'd1);
        check("call_tf", 32'(target_floor), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("hold_tf", 32'(target_floor), 32'd4);
            check("hold_tv", 32'(target_valid), 32'd1);
        end
        tick(12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("move_tv", 32'(target_valid), 32'd0);
        tick(12'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!door_open) break;
            n++;
            tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("door_len", 32'(n), 32'd8);
        check("call_cur", 32'(current_floor), 32'd4);
        check("call_pend", 32'(pending), 32'd0);

        // Same-floor call at floor 3 opens the door without a target
        go_floor(3);
        wait_door_end();
        tick(12'h008, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("same_tv", 32'(target_valid), 32'd0);
            check("same_door", 32'(door_open), 32'd1);
        end
        wait_door_end();

        // SCAN order from floor 4 going up with calls at 2, 6, 9
        go_floor(4);
        wait_door_end();
        check("scan_start_dir", 32'(dir_up), 32'd1);
        tick(12'h244, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) serve_next(fl[k], dr[k]);
        check("scan_1st", 32'(fl[0]), 32'd6);
        check("scan_2nd", 32'(fl[1]), 32'd9);
        check("scan_3rd", 32'(fl[2]), 32'd2);
        check("scan_dir_1st", 32'(dr[0]), 32'd1);
        check("scan_dir_3rd", 32'(dr[2]), 32'd0);

        // Discard at the open door, accumulate elsewhere
        go_floor(5);
        tick(12'h020, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(12'h100, 1'b1, 1'b0, 1'b0, 1'b1);
        check("discard_pend", 32'(pending), 32'h100);
        check("discard_door", 32'(door_open), 32'd1);

        // Reset in the middle of DOOR
        tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_pend", 32'(pending), 32'd0);
        check("mid_rst_cur",  32'(current_floor), 32'd0);
        check("mid_rst_tf",   32'(target_floor), 32'd0);
        check("mid_rst_tv",   32'(target_valid), 32'd0);
        check("mid_rst_door", 32'(door_open), 32'd0);
        check("mid_rst_dir",  32'(dir_up), 32'd1);
        tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("post_rst_door", 32'(door_open), 32'd0);

        // Arrived outside MOVE is ignored
        tick(12'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ign_idle_cur", 32'(current_floor), 32'd0);
        tick(12'h040, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(12'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ign_req_tv",  32'(target_valid), 32'd1);
        check("ign_req_cur", 32'(current_floor), 32'd0);
        tick(12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(12'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ign_move_cur", 32'(current_floor), 32'd6);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            tick(12'($urandom) & 12'hFFF,
                 logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 99) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/request_scheduler.md
REQUEST_SCHEDULER -- requirements
Module: request_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 12, number of served floors; equals the width of the press word.
REQ-002 Parameter DOOR_CYCLES, default 8, number of cycles door_open is held per stop.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-low.
REQ-005 Port press, input, NUM_FLOORS, floor-press vector; bit i = call at floor i; sourced from the random press generator or from buttons.
REQ-006 Port press_valid, input, 1, press is sampled on cycles where this is high.
REQ-007 Port target_floor, output, 4, floor the car is commanded to.
REQ-008 Port target_valid, output, 1, target_floor is offered to the motion controller.
REQ-009 Port target_ready, input, 1, motion controller accepts the target.
REQ-010 Port arrived, input, 1, single-cycle pulse: car has reached the accepted target.
REQ-011 Port door_open, output, 1, door open at current_floor.
REQ-012 Port dir_up, output, 1, scan direction: 1 = up, 0 = down.
REQ-013 Port current_floor, output, 4, last floor reached.
REQ-014 Port pending, output, NUM_FLOORS, outstanding calls.

Function
REQ-015 On each press_valid cycle, pending SHALL be updated to pending | press; the result is visible one cycle later.
REQ-016 The state machine SHALL have four states: IDLE, REQ, MOVE and DOOR.
REQ-017 In IDLE, the next target SHALL be chosen by SCAN:
- First choice: the nearest pending floor strictly beyond current_floor in dir_up.
- Otherwise: the nearest pending floor in the opposite direction, with dir_up toggled in the same cycle.
- Otherwise: remain in IDLE.
REQ-018 IDLE with pending[current_floor] set SHALL go directly to DOOR; that bit is cleared and no target is issued.
REQ-019 IDLE with another floor selected SHALL load target_floor and enter REQ on the next cycle.
REQ-020 In REQ, target_valid SHALL be 1 and target_floor SHALL be held stable until target_ready is sampled high; the FSM then enters MOVE and target_valid deasserts.
REQ-021 In MOVE, arrived SHALL cause the following, then entry to DOOR:
- current_floor is set to target_floor.
- pending[target_floor] is cleared.
REQ-022 arrived outside MOVE SHALL be ignored.
REQ-023 door_open SHALL be 1 for exactly DOOR_CYCLES consecutive cycles in DOOR, after which the FSM returns to IDLE.
REQ-024 A press at current_floor while in DOOR SHALL be discarded.
REQ-025 A press at target_floor arriving in the same cycle as the clear SHALL also be discarded: the clear wins.
REQ-026 A press at any other floor SHALL be accumulated in every state.
REQ-027 Floor indices at or above NUM_FLOORS SHALL never be selected.
REQ-028 The door counter SHALL be 8 bits and SHALL count without overflow for DOOR_CYCLES ≤ 255.

Reset
REQ-029 While rst is low at a clock edge, the block SHALL enter IDLE with these output values:
- pending, current_floor, target_floor = 0.
- target_valid, door_open = 0.
- dir_up = 1.
- door counter cleared.
REQ-030 A reset asserted during REQ, MOVE or DOOR SHALL abandon the operation; any outstanding handshake is dropped without completion.

Structure
REQ-031 A shared package elevator_pkg SHALL hold the following:
- state enum (IDLE, REQ, MOVE, DOOR).
- NUM_FLOORS_DEFAULT.
- floor_t (4-bit) typedef.
REQ-032 The SCAN selection SHALL be a combinational sub-module, scan_select, with these ports:
- inputs: pending, current_floor, dir_up.
- outputs: found, floor, dir_next.

Verification
REQ-033 Reset scenario: rst low for 2 cycles mid-DOOR -> all outputs at their reset values, FSM in IDLE, pending 0.
REQ-034 Single call scenario: press=12'h010 at floor 0 -> target_floor=4 with target_valid.
- Hold target_ready low for 3 cycles -> target_floor stable.
- Ready, then arrived -> current_floor=4, door_open for 8 cycles, pending=0.
REQ-035 SCAN order scenario: at floor 4 with dir_up=1, pending floors {2, 6, 9} -> served 6, 9, 2; dir_up goes 0 before floor 2 is issued.
REQ-036 Same-floor call scenario: in IDLE at floor 3, press=12'h008 -> DOOR directly, target_valid never asserted.
REQ-037 Discard/accumulate scenario: during DOOR at floor 5, press=12'h020 -> discarded; press=12'h100 -> kept (pending=12'h100).
REQ-038 Ignored arrived scenario: arrived pulse in IDLE or REQ -> no change to state or current_floor.
